// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the radix-2 Booth sequential multiplier.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // Step counter width for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    // Radix-2 Booth recoding of the pair {b[i], b[i-1]}.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: acc +/- (sign-extended a << cnt), carry out dropped.
module booth_step
    import booth_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [1:0]         pair,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] addend;

    assign addend = {{WIDTH{a[WIDTH-1]}}, a} << cnt;

    // Apply the recoded operation to the accumulator.
    always_comb begin
        acc_next = acc;
        case (booth_decode(pair))
            ADD:     acc_next = acc + addend;
            SUB:     acc_next = acc - addend;
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth signed multiplier with valid/ready on both sides.
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all equal (data-dependent latency, same results).
module booth_mult_seq
    import booth_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_sh;      // b arithmetically shifted right by cnt
    logic               guard;     // b[cnt-1], 0 on the first step
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     acc_hi;
    logic               last_step;
    logic               finish;
    logic               accept;

    booth_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .acc      (acc),
        .a        (a_r),
        .cnt      (cnt),
        .pair     ({b_sh[0], guard}),
        .acc_next (acc_next)
    );

    // Operands are taken in IDLE, or in DONE when the product is consumed the same edge.
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign acc_hi    = acc_next[2*WIDTH-1:WIDTH-1];

`ifdef BOOTH_EARLY_TERM_EN
    // Remaining multiplier bits all equal: every further step is a no-op.
    assign finish = last_step || (b_sh == '0) || (b_sh == '1);
`else
    assign finish = last_step;
`endif

    // Control FSM, step counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            product   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            a_r       <= '0;
            b_sh      <= '0;
            guard     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= a;
                        b_sh  <= b;
                        guard <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    cnt   <= cnt + CNT_W'(1);
                    guard <= b_sh[0];
                    b_sh  <= {b_sh[WIDTH-1], b_sh[WIDTH-1:1]};
                    if (finish) begin
                        product   <= acc_next;
                        ovf       <= !((acc_hi == '0) || (acc_hi == '1));
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_r   <= a;
                            b_sh  <= b;
                            guard <= 1'b0;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq at WIDTH=32.
module tb_booth_mult_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           ovf;

    int passed = 0;
    int total  = 0;
    int lat;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; caller ensures in_ready is high.
    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid, bounded.
    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 100) begin
            tick();
            l++;
        end
    endtask

    task automatic check_lat(input string tag, input int l);
`ifdef BOOTH_EARLY_TERM_EN
        check(tag, 64'(l >= 1 && l <= W), 64'd1);
`else
        check(tag, 64'(l), 64'(W));
`endif
    endtask

    // Full operation with out_ready held high; result left for checking.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [63:0] exp_p, input logic exp_ovf);
        out_ready = 1'b0;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        start(av, bv);
        wait_done(lat);
        check_lat({tag, "_lat"}, lat);
        check({tag, "_product"}, product, exp_p);
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_consumed"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        // Reset behaviour
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Basic products and edge operands
        run_op("m7x-3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        run_op("2p16sq", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        run_op("maxsq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1);
        run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);
        run_op("m7xm9", 32'hFFFF_FFF9, 32'hFFFF_FFF7, 64'd63, 1'b0);
        run_op("zero_a", 32'd0, 32'h0001_2345, 64'd0, 1'b0);
        run_op("zero_b", 32'h8765_4321, 32'd0, 64'd0, 1'b0);

        // Backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        start(32'd5, 32'd5);
        in_valid = 1'b1;
        a = 32'd99;
        b = 32'd99;
        #1;
        check("busy_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        check_lat("bp_lat", lat + 1);
        check("bp_product", product, 64'd25);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = $urandom;
            b = $urandom;
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_product", product, 64'd25);
            check("bp_hold_ovf", 64'(ovf), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end

        // Zero-bubble turnaround: consume and accept on the same edge
        a = 32'hFFFF_FFFC;
        b = 32'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("turn_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("turn_consumed", 64'(out_valid), 64'd0);
        check("turn_busy", 64'(in_ready), 64'd0);
        wait_done(lat);
        check_lat("turn_lat", lat);
        check("turn_product", product, 64'hFFFF_FFFF_FFFF_FFE8);
        check("turn_ovf", 64'(ovf), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-computation
        start(32'd123, 32'd456);
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", product, 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        run_op("post_rst", 32'd5, 32'd5, 64'd25, 1'b0);

`ifdef BOOTH_EARLY_TERM_EN
        // Early termination latencies
        start(32'd3, 32'd1);
        wait_done(lat);
        check("et_3x1_lat", 64'(lat), 64'd2);
        check("et_3x1_product", product, 64'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start(32'd3, 32'hFFFF_FFFF);
        wait_done(lat);
        check("et_3xm1_lat", 64'(lat), 64'd1);
        check("et_3xm1_product", product, 64'hFFFF_FFFF_FFFF_FFFD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
